// File: rtl/op2_pkg.sv
// Purpose : shared types for the operand-2 stage: shift-type encoding, FSM states, datapath width.
// Latency : n/a (types and constants only).
// Backpressure: n/a.
package op2_pkg;

  localparam int WORD_W = 32;

  // Encoding matches instruction bits op2[6:5].
  typedef enum logic [1:0] {
    LSL = 2'b00,
    LSR = 2'b01,
    ASR = 2'b10,
    ROR = 2'b11
  } shift_t;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_SHIFT = 2'b01,
    ST_DONE  = 2'b10
  } state_t;

endpackage

// File: rtl/op2_step_unit.sv
// Purpose : shifts a word plus carry by 0..STEP bit positions (LSL/LSR/ASR/ROR, or RRX).
// Latency : combinational.
// Backpressure: none; pure function of its inputs.
// Ports   : val/c = word and carry in, typ/rrx = operation, n = positions this step (<= STEP),
//           res/c_out = shifted word and last bit shifted out (c passes through when n == 0).
module op2_step_unit
  import op2_pkg::*;
#(
  parameter int STEP = 1
) (
  input  logic [WORD_W-1:0] val,
  input  logic              c,
  input  shift_t            typ,
  input  logic              rrx,
  input  logic [3:0]        n,
  output logic [WORD_W-1:0] res,
  output logic              c_out
);

  logic [WORD_W-1:0] v;
  logic              cc;
  logic              b;

  // Unrolled chain of single-bit steps; positions beyond n leave value and carry untouched.
  always_comb begin
    v  = val;
    cc = c;
    b  = 1'b0;
    for (int i = 0; i < STEP; i++) begin
      if (i < int'(n)) begin
        b = v[0];
        if (rrx) begin
          v  = {cc, v[WORD_W-1:1]};
          cc = b;
        end else begin
          case (typ)
            LSL: begin
              cc = v[WORD_W-1];
              v  = {v[WORD_W-2:0], 1'b0};
            end
            LSR: begin
              v  = {1'b0, v[WORD_W-1:1]};
              cc = b;
            end
            ASR: begin
              v  = {v[WORD_W-1], v[WORD_W-1:1]};
              cc = b;
            end
            default: begin
              // ROR: the bit rotated into [31] is also the carry
              v  = {b, v[WORD_W-1:1]};
              cc = b;
            end
          endcase
        end
      end
    end
    res   = v;
    c_out = cc;
  end

endmodule

// File: rtl/op2_shifter.sv
// Purpose : operand-2 generation (rotated imm8, or Rm shifted by imm/Rs amount) plus shifter carry-out.
// Latency : out_valid seen ceil(N_eff/STEP)+1 edges after accept; always 1 with OP2_BARREL_EN.
// Backpressure: one request in flight; result held in DONE until out_ready, in_ready low meanwhile.
// Ports   : clk, rst (async, active-high); in_valid/in_ready with imm_sel, op2[11:0], rm_val, rs_val, c_in;
//           out_valid/out_ready with op2_val, shift_c.
// Config  : define OP2_BARREL_EN for a single-cycle log-shifter datapath (STEP then unused).
module op2_shifter
  import op2_pkg::*;
#(
  parameter int STEP = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              imm_sel,
  input  logic [11:0]       op2,
  input  logic [WORD_W-1:0] rm_val,
  input  logic [7:0]        rs_val,
  input  logic              c_in,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [WORD_W-1:0] op2_val,
  output logic              shift_c
);

  state_t            state;

  logic [7:0]        amt;
  shift_t            sh_type;
  logic [WORD_W-1:0] dec_val;
  logic              dec_c;
  shift_t            dec_type;
  logic              dec_rrx;
  logic [5:0]        dec_n;

  assign amt     = op2[4] ? rs_val : {3'b000, op2[11:7]};
  assign sh_type = shift_t'(op2[6:5]);

  // Decode everything to (value, carry, op, count). Out-of-range amounts are folded so that
  // plain stepping by dec_n produces the architectural result: LSL/LSR > 32 start from a zero
  // word with zero carry, ASR > 32 behaves as ASR 32, ROR > 32 reduces mod 32 (0 -> 32).
  always_comb begin
    dec_val  = rm_val;
    dec_c    = c_in;
    dec_type = sh_type;
    dec_rrx  = 1'b0;
    dec_n    = amt[5:0];
    if (imm_sel) begin
      dec_val  = {{(WORD_W-8){1'b0}}, op2[7:0]};
      dec_type = ROR;
      dec_n    = {1'b0, op2[11:8], 1'b0};
    end else if (amt == 8'd0) begin
      dec_n = 6'd0;
      if (!op2[4]) begin
        case (sh_type)
          LSR, ASR: dec_n = 6'd32;
          ROR: begin
            dec_rrx = 1'b1;
            dec_n   = 6'd1;
          end
          default: dec_n = 6'd0;
        endcase
      end
    end else if (amt > 8'd32) begin
      dec_n = 6'd32;
      case (sh_type)
        LSL, LSR: begin
          dec_val = '0;
          dec_c   = 1'b0;
        end
        ROR:     dec_n = (amt[4:0] == 5'd0) ? 6'd32 : {1'b0, amt[4:0]};
        default: dec_n = 6'd32;
      endcase
    end
  end

`ifdef OP2_BARREL_EN
  // Whole shift in one go; returns {carry, word}.
  function automatic logic [WORD_W:0] barrel(input logic [WORD_W-1:0] val, input logic c,
                                             input shift_t typ, input logic rrx, input logic [5:0] n);
    logic [2*WORD_W-1:0] t;
    logic [WORD_W:0]     r;
    t = '0;
    r = {c, val};
    if (rrx) begin
      r = {val[0], c, val[WORD_W-1:1]};
    end else if (n != 6'd0) begin
      case (typ)
        LSL: begin
          t = {{WORD_W{1'b0}}, val} << n;
          r = {t[WORD_W], t[WORD_W-1:0]};
        end
        LSR: begin
          t = {val, {WORD_W{1'b0}}} >> n;
          r = {t[WORD_W-1], t[2*WORD_W-1:WORD_W]};
        end
        ASR: begin
          t = $signed({val, {WORD_W{1'b0}}}) >>> n;
          r = {t[WORD_W-1], t[2*WORD_W-1:WORD_W]};
        end
        default: begin
          t = {val, val} >> n;
          r = {t[WORD_W-1], t[WORD_W-1:0]};
        end
      endcase
    end
    return r;
  endfunction

  logic [WORD_W:0] bar_r;
  assign bar_r = barrel(dec_val, dec_c, dec_type, dec_rrx, dec_n);
`else
  logic [WORD_W-1:0] work_val;
  logic              work_c;
  shift_t            work_type;
  logic              work_rrx;
  logic [5:0]        cnt;
  logic [3:0]        step_n;
  logic [WORD_W-1:0] step_res;
  logic              step_c;

  // Full STEP per cycle, remainder on the last cycle.
  assign step_n = (cnt > 6'(STEP)) ? 4'(STEP) : cnt[3:0];

  op2_step_unit #(.STEP(STEP)) u_step (
    .val   (work_val),
    .c     (work_c),
    .typ   (work_type),
    .rrx   (work_rrx),
    .n     (step_n),
    .res   (step_res),
    .c_out (step_c)
  );
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= ST_IDLE;
      in_ready  <= 1'b0;
      out_valid <= 1'b0;
      op2_val   <= '0;
      shift_c   <= 1'b0;
`ifndef OP2_BARREL_EN
      work_val  <= '0;
      work_c    <= 1'b0;
      work_type <= LSL;
      work_rrx  <= 1'b0;
      cnt       <= '0;
`endif
    end else begin
      case (state)
        ST_IDLE: begin
          if (in_valid && in_ready) begin
            in_ready <= 1'b0;
`ifdef OP2_BARREL_EN
            op2_val   <= bar_r[WORD_W-1:0];
            shift_c   <= bar_r[WORD_W];
            out_valid <= 1'b1;
            state     <= ST_DONE;
`else
            work_val  <= dec_val;
            work_c    <= dec_c;
            work_type <= dec_type;
            work_rrx  <= dec_rrx;
            cnt       <= dec_n;
            if (dec_n == 6'd0) begin
              op2_val   <= dec_val;
              shift_c   <= dec_c;
              out_valid <= 1'b1;
              state     <= ST_DONE;
            end else begin
              state <= ST_SHIFT;
            end
`endif
          end else begin
            in_ready <= 1'b1;
          end
        end
        ST_SHIFT: begin
`ifdef OP2_BARREL_EN
          state    <= ST_IDLE;
          in_ready <= 1'b1;
`else
          work_val <= step_res;
          work_c   <= step_c;
          cnt      <= cnt - 6'(step_n);
          // Final step publishes the result directly so out_valid is not delayed a cycle.
          if (cnt <= 6'(STEP)) begin
            op2_val   <= step_res;
            shift_c   <= step_c;
            out_valid <= 1'b1;
            state     <= ST_DONE;
          end
`endif
        end
        ST_DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            state     <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_op2_shifter.sv
// Purpose : directed self-checking bench for op2_shifter (STEP=1) with hand-computed vectors.
// Latency : expected latencies are ceil(N/1)+1, or 1 when OP2_BARREL_EN is defined.
// Backpressure: exercises out_ready hold, back-to-back acceptance and reset abort.
module tb_op2_shifter;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic        imm_sel = 1'b0;
  logic [11:0] op2 = '0;
  logic [31:0] rm_val = '0;
  logic [7:0]  rs_val = '0;
  logic        c_in = 1'b0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] op2_val;
  logic        shift_c;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  op2_shifter #(.STEP(1)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .imm_sel   (imm_sel),
    .op2       (op2),
    .rm_val    (rm_val),
    .rs_val    (rs_val),
    .c_in      (c_in),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .op2_val   (op2_val),
    .shift_c   (shift_c)
  );

  // el < 0: latency not checked for that vector
  typedef struct {
    logic        imm;
    logic [11:0] op2;
    logic [31:0] rm;
    logic [7:0]  rs;
    logic        c;
    logic [31:0] ev;
    logic        ec;
    int          el;
  } vec_t;

  vec_t imm_vecs [4] = '{
    '{1'b1, 12'h4FF, 32'h0, 8'd0, 1'b0, 32'hFF000000, 1'b1, 9},
    '{1'b1, 12'h0AB, 32'h0, 8'd0, 1'b1, 32'h000000AB, 1'b1, 1},
    '{1'b1, 12'h1FF, 32'h0, 8'd0, 1'b0, 32'hC000003F, 1'b1, 3},
    '{1'b1, 12'h201, 32'h0, 8'd0, 1'b1, 32'h10000000, 1'b0, 5}
  };

  vec_t reg_imm_vecs [6] = '{
    '{1'b0, 12'h200, 32'hF0000001, 8'd0, 1'b0, 32'h00000010, 1'b1, 5},
    '{1'b0, 12'h020, 32'h80000000, 8'd0, 1'b0, 32'h00000000, 1'b1, 33},
    '{1'b0, 12'h040, 32'h80000000, 8'd0, 1'b0, 32'hFFFFFFFF, 1'b1, 33},
    '{1'b0, 12'h060, 32'h00000003, 8'd0, 1'b1, 32'h80000001, 1'b1, 2},
    '{1'b0, 12'hF80, 32'h00000003, 8'd0, 1'b0, 32'h80000000, 1'b1, 32},
    '{1'b0, 12'h000, 32'h12345678, 8'd0, 1'b1, 32'h12345678, 1'b1, 1}
  };

  vec_t rs_vecs [7] = '{
    '{1'b0, 12'h010, 32'h12345678, 8'd0,   1'b1, 32'h12345678, 1'b1, 1},
    '{1'b0, 12'h030, 32'hFFFFFFFF, 8'd40,  1'b1, 32'h00000000, 1'b0, 33},
    '{1'b0, 12'h070, 32'h0000000F, 8'd36,  1'b0, 32'hF0000000, 1'b1, -1},
    '{1'b0, 12'h010, 32'h00000001, 8'd32,  1'b0, 32'h00000000, 1'b1, 33},
    '{1'b0, 12'h050, 32'h80000000, 8'd8,   1'b1, 32'hFF800000, 1'b0, 9},
    '{1'b0, 12'h070, 32'h7FFFFFFF, 8'd32,  1'b1, 32'h7FFFFFFF, 1'b0, 33},
    '{1'b0, 12'h050, 32'h40000000, 8'd200, 1'b1, 32'h00000000, 1'b0, 33}
  };

  function automatic int exp_lat(input int l);
`ifdef OP2_BARREL_EN
    return (l < 0) ? l : 1;
`else
    return l;
`endif
  endfunction

  // Issue one request, scramble inputs after accept, wait (bounded) for the result, then consume it.
  // lat = edges from the accepting edge to the first edge that sees out_valid; -1 on timeout.
  task automatic issue(input vec_t v, output logic [31:0] val, output logic c, output int lat);
    int guard;
    guard = 0;
    @(negedge clk);
    while (!in_ready && guard < 100) begin
      @(negedge clk);
      guard++;
    end
    imm_sel  = v.imm;
    op2      = v.op2;
    rm_val   = v.rm;
    rs_val   = v.rs;
    c_in     = v.c;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    imm_sel  = ~v.imm;
    op2      = ~v.op2;
    rm_val   = ~v.rm;
    rs_val   = ~v.rs;
    c_in     = ~v.c;
    lat = 1;
    @(negedge clk);
    while (!out_valid && lat < 100) begin
      @(posedge clk);
      lat++;
      @(negedge clk);
    end
    if (!out_valid) lat = -1;
    val = op2_val;
    c   = shift_c;
    out_ready = 1'b1;
    @(posedge clk);
    #1 out_ready = 1'b0;
  endtask

  task automatic test_reset();
    #2 rst = 1'b1;
    @(negedge clk);
    total++;
    if (out_valid !== 1'b0 || op2_val !== 32'h0 || shift_c !== 1'b0) begin
      bad++;
      $display("FAIL reset_outputs: out_valid=%b op2_val=%h shift_c=%b, required 0 00000000 0",
               out_valid, op2_val, shift_c);
    end
    total++;
    if (in_ready !== 1'b0) begin
      bad++;
      $display("FAIL reset_in_ready: got %b, required 0", in_ready);
    end
    rst = 1'b0;
    @(posedge clk);
    #1;
    total++;
    if (in_ready !== 1'b1) begin
      bad++;
      $display("FAIL idle_in_ready: got %b, required 1", in_ready);
    end
  endtask

  task automatic test_immediate();
    logic [31:0] v;
    logic        c;
    int          lat;
    foreach (imm_vecs[i]) begin
      issue(imm_vecs[i], v, c, lat);
      total++;
      if (v !== imm_vecs[i].ev) begin
        bad++;
        $display("FAIL imm[%0d]_val: got %h, required %h", i, v, imm_vecs[i].ev);
      end
      total++;
      if (c !== imm_vecs[i].ec) begin
        bad++;
        $display("FAIL imm[%0d]_carry: got %b, required %b", i, c, imm_vecs[i].ec);
      end
      if (imm_vecs[i].el >= 0) begin
        total++;
        if (lat != exp_lat(imm_vecs[i].el)) begin
          bad++;
          $display("FAIL imm[%0d]_latency: got %0d, required %0d", i, lat, exp_lat(imm_vecs[i].el));
        end
      end
    end
  endtask

  task automatic test_reg_imm_shift();
    logic [31:0] v;
    logic        c;
    int          lat;
    foreach (reg_imm_vecs[i]) begin
      issue(reg_imm_vecs[i], v, c, lat);
      total++;
      if (v !== reg_imm_vecs[i].ev) begin
        bad++;
        $display("FAIL regimm[%0d]_val: got %h, required %h", i, v, reg_imm_vecs[i].ev);
      end
      total++;
      if (c !== reg_imm_vecs[i].ec) begin
        bad++;
        $display("FAIL regimm[%0d]_carry: got %b, required %b", i, c, reg_imm_vecs[i].ec);
      end
      if (reg_imm_vecs[i].el >= 0) begin
        total++;
        if (lat != exp_lat(reg_imm_vecs[i].el)) begin
          bad++;
          $display("FAIL regimm[%0d]_latency: got %0d, required %0d", i, lat,
                   exp_lat(reg_imm_vecs[i].el));
        end
      end
    end
  endtask

  task automatic test_reg_rs_shift();
    logic [31:0] v;
    logic        c;
    int          lat;
    foreach (rs_vecs[i]) begin
      issue(rs_vecs[i], v, c, lat);
      total++;
      if (v !== rs_vecs[i].ev) begin
        bad++;
        $display("FAIL rs[%0d]_val: got %h, required %h", i, v, rs_vecs[i].ev);
      end
      total++;
      if (c !== rs_vecs[i].ec) begin
        bad++;
        $display("FAIL rs[%0d]_carry: got %b, required %b", i, c, rs_vecs[i].ec);
      end
      if (rs_vecs[i].el >= 0) begin
        total++;
        if (lat != exp_lat(rs_vecs[i].el)) begin
          bad++;
          $display("FAIL rs[%0d]_latency: got %0d, required %0d", i, lat, exp_lat(rs_vecs[i].el));
        end
      end
    end
  endtask

  // Result must stay put while out_ready is low, with a competing request on the input ignored.
  task automatic test_hold();
    int guard;
    guard = 0;
    @(negedge clk);
    while (!in_ready && guard < 100) begin
      @(negedge clk);
      guard++;
    end
    imm_sel = 1'b0; op2 = 12'h200; rm_val = 32'hF0000001; rs_val = 8'd0; c_in = 1'b0;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    imm_sel = 1'b1; op2 = 12'h0AB; c_in = 1'b0;
    guard = 0;
    @(negedge clk);
    while (!out_valid && guard < 100) begin
      @(negedge clk);
      guard++;
    end
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      total++;
      if (out_valid !== 1'b1 || op2_val !== 32'h00000010 || shift_c !== 1'b1 || in_ready !== 1'b0) begin
        bad++;
        $display("FAIL hold[%0d]: out_valid=%b op2_val=%h shift_c=%b in_ready=%b, required 1 00000010 1 0",
                 k, out_valid, op2_val, shift_c, in_ready);
      end
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(posedge clk);
    #1 out_ready = 1'b0;
    total++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      bad++;
      $display("FAIL hold_release: out_valid=%b in_ready=%b, required 0 1", out_valid, in_ready);
    end
  endtask

  // A pending request is accepted on the edge after the one that consumed the previous result.
  task automatic test_back_to_back();
    int guard;
    guard = 0;
    @(negedge clk);
    while (!in_ready && guard < 100) begin
      @(negedge clk);
      guard++;
    end
    imm_sel = 1'b0; op2 = 12'h060; rm_val = 32'h00000003; rs_val = 8'd0; c_in = 1'b1;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    imm_sel = 1'b1; op2 = 12'h0AB; c_in = 1'b0;
    guard = 0;
    @(negedge clk);
    while (!out_valid && guard < 100) begin
      @(negedge clk);
      guard++;
    end
    total++;
    if (out_valid !== 1'b1 || op2_val !== 32'h80000001) begin
      bad++;
      $display("FAIL b2b_first: out_valid=%b op2_val=%h, required 1 80000001", out_valid, op2_val);
    end
    out_ready = 1'b1;
    @(posedge clk);
    #1 out_ready = 1'b0;
    total++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      bad++;
      $display("FAIL b2b_gap: out_valid=%b in_ready=%b, required 0 1", out_valid, in_ready);
    end
    @(posedge clk);
    #1 in_valid = 1'b0;
    total++;
    if (in_ready !== 1'b0 || out_valid !== 1'b1 || op2_val !== 32'h000000AB || shift_c !== 1'b0) begin
      bad++;
      $display("FAIL b2b_second: in_ready=%b out_valid=%b op2_val=%h shift_c=%b, required 0 1 000000AB 0",
               in_ready, out_valid, op2_val, shift_c);
    end
    out_ready = 1'b1;
    @(posedge clk);
    #1 out_ready = 1'b0;
  endtask

  // Reset mid-operation clears the outputs and no result appears afterwards.
  task automatic test_reset_abort();
    int          guard;
    int          spurious;
    logic [31:0] v;
    logic        c;
    int          lat;
    guard = 0;
    spurious = 0;
    @(negedge clk);
    while (!in_ready && guard < 100) begin
      @(negedge clk);
      guard++;
    end
    imm_sel = 1'b0; op2 = 12'h020; rm_val = 32'h80000000; rs_val = 8'd0; c_in = 1'b0;
    in_valid = 1'b1;
    @(posedge clk);
    #1 in_valid = 1'b0;
    repeat (5) @(negedge clk);
    rst = 1'b1;
    #1;
    total++;
    if (out_valid !== 1'b0 || op2_val !== 32'h0 || shift_c !== 1'b0 || in_ready !== 1'b0) begin
      bad++;
      $display("FAIL abort_reset: out_valid=%b op2_val=%h shift_c=%b in_ready=%b, required 0 00000000 0 0",
               out_valid, op2_val, shift_c, in_ready);
    end
    @(negedge clk);
    rst = 1'b0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (out_valid !== 1'b0) spurious++;
    end
    total++;
    if (spurious != 0) begin
      bad++;
      $display("FAIL abort_spurious_valid: got %0d cycles with out_valid, required 0", spurious);
    end
    total++;
    if (in_ready !== 1'b1) begin
      bad++;
      $display("FAIL abort_idle: in_ready=%b, required 1", in_ready);
    end
    issue(imm_vecs[0], v, c, lat);
    total++;
    if (v !== 32'hFF000000 || c !== 1'b1) begin
      bad++;
      $display("FAIL abort_recover: op2_val=%h shift_c=%b, required FF000000 1", v, c);
    end
  endtask

  initial begin
    test_reset();
    test_immediate();
    test_reg_imm_shift();
    test_reg_rs_shift();
    test_hold();
    test_back_to_back();
    test_reset_abort();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/op2_shifter.md
Name: op2_shifter

Overview:
- Operand-2 generation stage for the data-processing datapath; sits between decode and the ALU.
- Produces the 32-bit second ALU operand and the shifter carry-out from the 12-bit operand-2 field.
- Covers the rotated 8-bit immediate form and register forms shifted by immediate or register amount (LSL/LSR/ASR/ROR/RRX).
- Iterative: STEP bit positions per cycle, valid/ready on both sides.

Parameters:
- STEP, 1, bit positions shifted per cycle; legal values 1, 2, 4, 8.

Ports:
- clk  input  1  clock.
- rst  input  1  reset; asynchronous, active-high. This is already decided.
- in_valid  input  1  request valid.
- in_ready  output  1  stage can accept a request.
- imm_sel  input  1  1 = immediate form (I bit).
- op2  input  12  operand-2 field of the instruction.
- rm_val  input  32  Rm register value.
- rs_val  input  8  Rs[7:0], the shift amount for register-specified shifts.
- c_in  input  1  current C flag.
- out_valid  output  1  result valid.
- out_ready  input  1  consumer accepts the result.
- op2_val  output  32  operand-2 result.
- shift_c  output  1  shifter carry-out.

Behaviour:
- States:
  - IDLE: in_ready=1.
  - SHIFT: stepping.
  - DONE: out_valid=1.
- Reset: all outputs zero, in_ready=0 while rst is high, FSM returns to IDLE, result registers cleared.
- Accept: in_valid && in_ready in IDLE latches all inputs. Inputs are don't-care afterwards.
- Decode at accept:
  - Immediate form:
    - value = {24'b0, op2[7:0]}, rotate right by N = 2*op2[11:8].
    - carry = c_in if N==0, else the final result bit 31.
  - Register form, op2[4]=0 (shift amount from immediate):
    - amt = op2[11:7], type = op2[6:5].
    - LSR #0 and ASR #0 mean 32.
    - ROR #0 means RRX: result = {c_in, rm[31:1]}, carry = rm[0]; one step.
  - Register form, op2[4]=1 (shift amount from Rs):
    - amt = rs_val[7:0].
    - amt==0: result = rm, carry = c_in.
  - Clamp for amt > 32:
    - LSL/LSR: result 0, carry 0.
    - ASR: all sign bits, carry = rm[31].
    - ROR: amt mod 32, where 0 means 32; for 32, result = rm, carry = rm[31].
- Step count:
  - N_eff = min(amt, 32), or 1 for RRX.
  - Cycles in SHIFT = ceil(N_eff / STEP); the last step shifts the remainder only.
  - N_eff==0 goes straight to DONE.
- Latency: out_valid rises exactly ceil(N_eff/STEP)+1 cycles after the accepting edge.
- Carry rule: the carry is the last bit shifted out (LSL: bit 32-amt; LSR/ASR: bit amt-1; ROR: result[31]).
- DONE:
  - op2_val and shift_c stay stable while out_valid && !out_ready.
  - On out_ready, return to IDLE; in_ready=1 the next cycle (no same-cycle re-accept).
- rst during SHIFT or DONE aborts the operation; no out_valid is produced.
- in_valid is ignored outside IDLE.

Optional Feature:
- OP2_BARREL_EN defined:
  - Replaces the iterative datapath with a single-cycle log-shifter; STEP is ignored.
  - Latency is always 1 cycle (accept edge, then out_valid); the SHIFT state is unused.
  - Results are bit-identical to the iterative build.
- Undefined: iterative datapath as above.

Decomposition:
- Shared package op2_pkg holds:
  - shift type enum: LSL=2'b00, LSR=2'b01, ASR=2'b10, ROR=2'b11.
  - FSM state enum.
  - constant WORD_W=32.
- Sub-module op2_step_unit: combinational, shifts a 32-bit value plus carry by 0..STEP positions for a given type. Instantiated once in the iterative build.

Test Plan:
1. imm_sel=1, op2=12'h4FF, c_in=0, STEP=1 → op2_val=32'hFF000000, shift_c=1, out_valid 9 cycles after accept. Same op2 with OP2_BARREL_EN gives out_valid after 1 cycle.
2. Register LSL #4 (op2=12'h200), rm=32'hF0000001 → op2_val=32'h00000010, shift_c=1. With op2[11:8]=0, imm_sel=1, op2=12'h0AB, c_in=1 → 32'h000000AB, shift_c=1, latency 1.
3. LSR #0 (op2=12'h020), rm=32'h80000000 → 0, shift_c=1. ASR #0 (op2=12'h040) on the same rm → 32'hFFFFFFFF, shift_c=1.
4. RRX (op2=12'h060), rm=32'h3, c_in=1 → op2_val=32'h80000001, shift_c=1.
5. Register shift from Rs:
   - LSL, rs=0, c_in=1 → rm unchanged, shift_c=1, latency 1.
   - LSR, rs=40 → 0, shift_c=0.
   - ROR, rs=36, rm=32'h0000000F → 32'hF0000000, shift_c=1.
6. Hold, back-to-back and reset:
   - out_ready held low 5 cycles → result stable, in_ready=0.
   - Back-to-back requests are accepted one cycle after out_ready.
   - rst pulsed mid-SHIFT → outputs 0, IDLE, no spurious out_valid.
